// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the 32-bit word type and stage-register constants.
// The PC_STEP helper keeps every stage computing PC+PC_STEP the same way.
package pipeline_pkg;

   typedef logic [31:0] word_t;

   localparam word_t PIPE_RESET_PC  = 32'h0000_0000;
   localparam word_t PIPE_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
   localparam word_t PIPE_PC_STEP   = 32'd4;

   // Modulo-2^32 sequential address; 32'hFFFF_FFFC + 4 wraps to 0.
   function automatic word_t next_seq(input word_t addr, input word_t step);
      return addr + step;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > hold > memory-wait bubble > load priority.
// The accept output marks an edge that captures a real instruction.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter word_t NOP_INSTR = PIPE_NOP_INSTR
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  flush,
   input  logic  write,
   input  logic  ready,
   input  word_t instr_in,
   input  word_t pc4_in,
   output word_t instr,
   output word_t pc4,
   output logic  valid,
   output logic  accept
);

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      accept = 1'b0;
      if (!flush && write && ready)
         accept = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (write) begin
         // A memory wait still records pc4 but marks the slot as a bubble.
         instr <= ready ? instr_in : NOP_INSTR;
         pc4   <= pc4_in;
         valid <= ready;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, fetch counter and the IF/ID register.
// Redirects override both PCWrite and a pending slow fetch.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter word_t RESET_PC  = PIPE_RESET_PC,
   parameter word_t NOP_INSTR = PIPE_NOP_INSTR,
   parameter word_t PC_STEP   = PIPE_PC_STEP
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  PCWrite,
   input  logic  If_Id_write,
   input  logic  If_Id_flush,
   input  logic  PCsource,
   input  word_t branch_target,
   input  logic  jump,
   input  word_t jump_target,
   output word_t imem_addr,
   input  word_t imem_data,
   input  logic  imem_ready,
   output word_t pc,
   output word_t If_Id_instr,
   output word_t If_Id_pc4,
   output logic  If_Id_valid,
   output word_t fetch_count
);

   word_t pc_q;
   word_t pc_plus;
   word_t count_q;
   logic  accept;

   assign pc_plus     = next_seq(pc_q, PC_STEP);
   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign fetch_count = count_q;

   // Branch resolves later than jump, so a simultaneous jump is on the wrong path.
   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_PC;
      else if (PCsource)
         pc_q <= branch_target;
      else if (jump)
         pc_q <= jump_target;
      else if (PCWrite && imem_ready)
         pc_q <= pc_plus;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else if (accept)
         count_q <= count_q + 32'd1;
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .flush    (If_Id_flush),
      .write    (If_Id_write),
      .ready    (imem_ready),
      .instr_in (imem_data),
      .pc4_in   (pc_plus),
      .instr    (If_Id_instr),
      .pc4      (If_Id_pc4),
      .valid    (If_Id_valid),
      .accept   (accept)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural model checked every cycle,
// plus hand-computed literal expectations at each scenario's key points.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCWrite, If_Id_write, If_Id_flush, PCsource, jump, imem_ready;
   logic [31:0] branch_target, jump_target, imem_data, imem_addr;
   logic [31:0] pc, If_Id_instr, If_Id_pc4, fetch_count;
   logic        If_Id_valid;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   always #5 clk = ~clk;

   // Instruction memory contents: distinct from NOP at every address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hC0DE_0001;
   endfunction

   assign imem_data = mem(imem_addr);

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .PCWrite       (PCWrite),
      .If_Id_write   (If_Id_write),
      .If_Id_flush   (If_Id_flush),
      .PCsource      (PCsource),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .imem_ready    (imem_ready),
      .pc            (pc),
      .If_Id_instr   (If_Id_instr),
      .If_Id_pc4     (If_Id_pc4),
      .If_Id_valid   (If_Id_valid),
      .fetch_count   (fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the stage must hold after each edge.
   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid;
   logic [31:0] m_next;

   always @(posedge clk) begin
      if (reset) begin
         m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
      end else begin
         m_next = m_pc + 32'd4;
         if (If_Id_flush) begin
            m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
         end else if (If_Id_write) begin
            if (imem_ready) begin
               m_instr = mem(m_pc); m_valid = 1'b1; m_count = m_count + 32'd1;
            end else begin
               m_instr = NOP; m_valid = 1'b0;
            end
            m_pc4 = m_next;
         end
         if (PCsource)                  m_pc = branch_target;
         else if (jump)                 m_pc = jump_target;
         else if (PCWrite && imem_ready) m_pc = m_next;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_pc",        pc,                 m_pc);
         check("cyc_imem_addr", imem_addr,          m_pc);
         check("cyc_instr",     If_Id_instr,        m_instr);
         check("cyc_pc4",       If_Id_pc4,          m_pc4);
         check("cyc_valid",     {31'b0, If_Id_valid}, {31'b0, m_valid});
         check("cyc_count",     fetch_count,        m_count);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      PCWrite = 1'b1; If_Id_write = 1'b1; If_Id_flush = 1'b0;
      PCsource = 1'b0; jump = 1'b0; imem_ready = 1'b1;
   endtask

   task automatic redirect_jump(input logic [31:0] t);
      jump = 1'b1; jump_target = t; If_Id_flush = 1'b1;
      cyc();
      idle();
   endtask

   logic [31:0] c0;

   initial begin
      reset = 1'b1; branch_target = 32'h0; jump_target = 32'h0;
      idle();
      cyc();
      chk_en = 1'b1;
      check("rst_pc",    pc,          32'h0);
      check("rst_instr", If_Id_instr, NOP);
      check("rst_pc4",   If_Id_pc4,   32'h0);
      check("rst_valid", {31'b0, If_Id_valid}, 32'h0);
      check("rst_count", fetch_count, 32'h0);
      reset = 1'b0;

      // Straight-line fetch: pc 0 -> 16, pc4 lags one cycle.
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("seq_pc",  pc,        32'(4 * i));
         check("seq_pc4", If_Id_pc4, 32'(4 * i));
      end
      check("seq_instr", If_Id_instr, mem(32'd12));
      check("seq_count", fetch_count, 32'd4);

      // Load-use stall at pc=8.
      reset = 1'b1; cyc(); reset = 1'b0;
      cyc(); cyc();
      PCWrite = 1'b0; If_Id_write = 1'b0;
      cyc();
      check("stall_pc",    pc,          32'h8);
      check("stall_instr", If_Id_instr, mem(32'h4));
      check("stall_pc4",   If_Id_pc4,   32'h8);
      check("stall_count", fetch_count, 32'd2);
      idle();

      // Jump with flush, then fetch from the target.
      redirect_jump(32'h100);
      check("jmp_pc",    pc,          32'h100);
      check("jmp_valid", {31'b0, If_Id_valid}, 32'h0);
      check("jmp_instr", If_Id_instr, NOP);
      cyc();
      check("jmp_fetch", If_Id_instr, mem(32'h100));
      check("jmp_pc4",   If_Id_pc4,   32'h104);

      // Branch beats a simultaneous jump, even with PCWrite=0.
      PCsource = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h200;
      PCWrite = 1'b0; If_Id_flush = 1'b1;
      cyc();
      check("brj_pc",    pc, 32'h40);
      check("brj_valid", {31'b0, If_Id_valid}, 32'h0);
      idle();

      // Flush wins over If_Id_write=0.
      cyc();
      If_Id_flush = 1'b1; If_Id_write = 1'b0; PCWrite = 1'b0;
      cyc();
      check("flw_instr", If_Id_instr, NOP);
      check("flw_pc",    pc,          32'h44);
      idle();

      // Memory wait at pc=0x20 for 3 cycles.
      redirect_jump(32'h20);
      c0 = fetch_count;
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("wait_pc",  pc,        32'h20);
         check("wait_pc4", If_Id_pc4, 32'h24);
      end
      check("wait_count", fetch_count, c0);
      imem_ready = 1'b1;
      cyc();
      check("wait_instr", If_Id_instr, mem(32'h20));
      check("wait_pc4r",  If_Id_pc4,   32'h24);

      // Unaligned branch during a memory wait: redirect still taken.
      imem_ready = 1'b0; PCsource = 1'b1; branch_target = 32'h43;
      cyc();
      check("una_pc", pc, 32'h43);
      idle();
      cyc();
      check("una_next", pc, 32'h47);

      // Wrap from the top of the address space.
      redirect_jump(32'hFFFF_FFFC);
      cyc();
      check("wrap_pc",  pc,        32'h0);
      check("wrap_pc4", If_Id_pc4, 32'h0);

      // Reset asserted during a stall.
      PCWrite = 1'b0; If_Id_write = 1'b0; reset = 1'b1;
      cyc();
      check("mrst_pc",    pc,          32'h0);
      check("mrst_instr", If_Id_instr, NOP);
      check("mrst_count", fetch_count, 32'h0);
      reset = 1'b0; idle();
      cyc();
      check("mrst_next", pc, 32'h4);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It owns the PC and drives the instruction-memory address. It latches the fetched instruction and PC+4 into IF/ID. It obeys the hazard controller's PCWrite / If_Id_write / If_Id_flush outputs and takes the branch/jump redirects resolved downstream. Its IF/ID outputs feed decode and the hazard controller's register-compare inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
PCWrite  in  1  from hazard controller; 0 = hold PC
If_Id_write  in  1  from hazard controller; 0 = hold IF/ID
If_Id_flush  in  1  from hazard controller; 1 = load bubble into IF/ID
PCsource  in  1  branch taken (resolved in EX/MEM)
branch_target  in  32  byte address for taken branch
jump  in  1  jump decoded in ID
jump_target  in  32  byte address for jump
imem_addr  out  32  equals current PC (combinational from PC register)
imem_data  in  32  instruction word, valid same cycle when imem_ready=1
imem_ready  in  1  1 = imem_data valid this cycle
pc  out  32  current PC register
If_Id_instr  out  32  latched instruction
If_Id_pc4  out  32  latched PC+PC_STEP of that instruction
If_Id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
fetch_count  out  32  number of instructions accepted into IF/ID (wraps)

Behaviour:
- Reset (synchronous, highest priority): pc=RESET_PC, If_Id_instr=NOP_INSTR, If_Id_pc4=0, If_Id_valid=0, fetch_count=0.
- imem_addr = pc at all times; zero-latency combinational memory with a ready handshake.
- PC next-state priority, evaluated each rising edge when not in reset:
  1. PCsource=1: pc <= branch_target.
  2. else jump=1: pc <= jump_target.
  3. else PCWrite=0: hold.
  4. else imem_ready=0: hold, waiting on memory.
  5. else pc <= pc + PC_STEP, 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Redirects (1, 2) apply regardless of PCWrite and imem_ready. A pending slow fetch is abandoned; the new address is presented next cycle.
- IF/ID next-state priority:
  1. If_Id_flush=1: instr <= NOP_INSTR, pc4 <= 0, valid <= 0.
  2. else If_Id_write=0: hold all IF/ID fields (load-use stall).
  3. else imem_ready=0: instr <= NOP_INSTR, valid <= 0, pc4 <= pc+PC_STEP (bubble).
  4. else instr <= imem_data, pc4 <= pc+PC_STEP, valid <= 1.
- fetch_count increments by 1 exactly when IF/ID case 4 occurs; wraps at 2^32.
- Simultaneous flush and If_Id_write=0: flush wins.
- Simultaneous PCsource and jump: branch wins, the jump is on the wrong path.
- Unaligned targets are not checked: bits [1:0] pass through unchanged.
- Reset asserted mid-stall or mid-redirect: reset values next edge, no residual state.
- Latency: instruction at pc appears on If_Id_instr one clock after the edge where imem_ready=1 and no flush/hold.

Decomposition:
- Shared package pipeline_pkg: NOP_INSTR, RESET_PC, PC_STEP, and a 32-bit word typedef used by all stage registers.
- Sub-module if_id_reg: IF/ID register with flush/hold/bubble priority and the valid bit.
- fetch_stage contains the PC register, next-PC mux, and fetch_count.

Test Plan:
- Reset, then 4 cycles with imem_ready=1 and controls idle -> pc = 0,4,8,12,16; If_Id_pc4 lags pc by one cycle (4,8,12,16); fetch_count=4.
- Load-use stall: PCWrite=0, If_Id_write=0 for 1 cycle at pc=8 -> pc stays 8; IF/ID holds the instruction from 4; fetch_count does not increment.
- Jump: jump=1, jump_target=0x100, If_Id_flush=1 -> next cycle pc=0x100, If_Id_valid=0, If_Id_instr=NOP; the following cycle fetches 0x100.
- Branch with jump: PCsource=1, branch_target=0x40, jump=1, jump_target=0x200, PCWrite=0 -> pc=0x40; IF/ID flushed.
- Memory wait: imem_ready=0 for 3 cycles at pc=0x20 -> pc holds 0x20; 3 bubbles with valid=0; on ready, instruction from 0x20 latched with pc4=0x24.
- Wrap and mid-op reset: pc=0xFFFF_FFFC advances to 0; reset asserted during an If_Id_write=0 stall -> all outputs at reset values next edge.
